tag_lookup_unit: RTL and testbench

TAG_LOOKUP_UNIT -- requirements
Module: tag_lookup_unit

---
 rtl/tag_lookup_unit.sv | 136 +++++++++++++
 tb/tb_tag_lookup_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/tag_lookup_unit.sv
// rtl/tag_lookup_unit.sv - set-associative tag array with registered lookup and victim select
//
// Purpose: holds number_of_sets tags, valid bits and a round-robin refill
// pointer for each of number_of_lines lines. A lookup compares the request tag
// against every valid way of the indexed line and returns hit, hitting way and
// a refill victim one cycle later through a single-entry output buffer.
//
// Ports:
//   clk            in   clock, all logic on the rising edge
//   reset          in   synchronous active-high reset
//   req_valid      in   lookup request present
//   req_ready      out  request accepted this cycle when high with req_valid
//   req_index      in   line to look up
//   req_tag        in   tag to compare
//   resp_valid     out  lookup result present
//   resp_ready     in   consumer takes the result
//   resp_hit       out  a valid way matched
//   resp_way       out  lowest matching way, 0 on miss
//   resp_victim    out  way to refill on miss
//   fill_valid     in   write one tag this cycle
//   fill_index     in   line to write
//   fill_tag       in   tag to write
//   fill_way       in   way to write
//   invalidate_all in   clear every valid bit and pointer

module tag_lookup_unit #(
  parameter int number_of_sets         = 4,
  parameter int bits_for_tag           = 20,
  parameter int log_of_number_of_sets  = 2,
  parameter int number_of_lines        = 64,
  parameter int log_of_number_of_lines = 6
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic [log_of_number_of_lines-1:0] req_index,
  input  logic [bits_for_tag-1:0]           req_tag,
  output logic                              resp_valid,
  input  logic                              resp_ready,
  output logic                              resp_hit,
  output logic [log_of_number_of_sets-1:0]  resp_way,
  output logic [log_of_number_of_sets-1:0]  resp_victim,
  input  logic                              fill_valid,
  input  logic [log_of_number_of_lines-1:0] fill_index,
  input  logic [bits_for_tag-1:0]           fill_tag,
  input  logic [log_of_number_of_sets-1:0]  fill_way,
  input  logic                              invalidate_all
);

  localparam int LW = log_of_number_of_sets;

  logic [bits_for_tag-1:0]   r_tags  [number_of_lines][number_of_sets];
  logic [number_of_sets-1:0] r_valid [number_of_lines];
  logic [LW-1:0]             r_ptr   [number_of_lines];

  logic          r_resp_valid;
  logic          r_resp_hit;
  logic [LW-1:0] r_resp_way;
  logic [LW-1:0] r_resp_victim;

  logic          w_accept;
  logic          w_hit;
  logic [LW-1:0] w_way;
  logic          w_has_invalid;
  logic [LW-1:0] w_invalid_way;
  logic [LW-1:0] w_victim;
  logic [LW-1:0] w_ptr_next;

  // Output buffer can take a new result whenever it is empty or being drained.
  assign req_ready = !r_resp_valid || resp_ready;
  assign w_accept  = req_valid && req_ready;

  // Lookup reads the flops directly, so a same-cycle fill or invalidate is
  // not yet visible here. Scanning from the top way down lets the lowest
  // matching / lowest invalid way win.
  always_comb begin
    w_hit         = 1'b0;
    w_way         = '0;
    w_has_invalid = 1'b0;
    w_invalid_way = '0;
    for (int i = number_of_sets - 1; i >= 0; i--) begin
      if (r_valid[req_index][i] && (r_tags[req_index][i] == req_tag)) begin
        w_hit = 1'b1;
        w_way = LW'(i);
      end
      if (!r_valid[req_index][i]) begin
        w_has_invalid = 1'b1;
        w_invalid_way = LW'(i);
      end
    end
    w_victim = w_has_invalid ? w_invalid_way : r_ptr[req_index];
  end

  // Pointer advance wraps explicitly so non-power-of-two way counts work.
  assign w_ptr_next = (r_ptr[fill_index] == LW'(number_of_sets - 1))
                    ? '0 : r_ptr[fill_index] + LW'(1);

  // Array state: invalidate_all beats a same-cycle fill; tags never reset.
  always_ff @(posedge clk) begin
    if (reset || invalidate_all) begin
      for (int l = 0; l < number_of_lines; l++) begin
        r_valid[l] <= '0;
        r_ptr[l]   <= '0;
      end
    end else if (fill_valid) begin
      r_tags[fill_index][fill_way]  <= fill_tag;
      r_valid[fill_index][fill_way] <= 1'b1;
      r_ptr[fill_index]             <= w_ptr_next;
    end
  end

  // Response buffer: result is captured only on accept, so a held response
  // never picks up later array changes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_resp_valid  <= 1'b0;
      r_resp_hit    <= 1'b0;
      r_resp_way    <= '0;
      r_resp_victim <= '0;
    end else if (w_accept) begin
      r_resp_valid  <= 1'b1;
      r_resp_hit    <= w_hit;
      r_resp_way    <= w_way;
      r_resp_victim <= w_victim;
    end else if (resp_ready) begin
      r_resp_valid  <= 1'b0;
    end
  end

  assign resp_valid  = r_resp_valid;
  assign resp_hit    = r_resp_hit;
  assign resp_way    = r_resp_way;
  assign resp_victim = r_resp_victim;

endmodule

// File: tb/tb_tag_lookup_unit.sv
// tb/tb_tag_lookup_unit.sv - table-driven scoreboard bench for tag_lookup_unit
module tb_tag_lookup_unit;

  typedef struct {
    logic        rv;
    logic [5:0]  idx;
    logic [19:0] tag;
    logic        fv;
    logic [5:0]  fidx;
    logic [1:0]  fway;
    logic [19:0] ftag;
    logic        inv;
    logic        eh;
    logic [1:0]  ew;
    logic [1:0]  ev;
  } vec_t;

  typedef struct {
    logic       hit;
    logic [1:0] way;
    logic [1:0] vic;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [5:0]  req_index = '0;
  logic [19:0] req_tag = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic        resp_hit;
  logic [1:0]  resp_way;
  logic [1:0]  resp_victim;
  logic        fill_valid = 1'b0;
  logic [5:0]  fill_index = '0;
  logic [19:0] fill_tag = '0;
  logic [1:0]  fill_way = '0;
  logic        invalidate_all = 1'b0;

  int   checks = 0;
  int   failures = 0;
  exp_t exp_cur;
  exp_t sb[$];
  vec_t tbl[$];
  logic pend = 1'b0;

  always #5 clk = ~clk;

  tag_lookup_unit dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_index(req_index), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_hit(resp_hit), .resp_way(resp_way), .resp_victim(resp_victim),
    .fill_valid(fill_valid), .fill_index(fill_index), .fill_tag(fill_tag),
    .fill_way(fill_way), .invalidate_all(invalidate_all)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic rv, input logic [5:0] idx, input logic [19:0] tag,
                              input logic fv, input logic [5:0] fidx, input logic [1:0] fway,
                              input logic [19:0] ftag, input logic inv,
                              input logic eh, input logic [1:0] ew, input logic [1:0] ev);
    vec_t v;
    v.rv = rv; v.idx = idx; v.tag = tag; v.fv = fv; v.fidx = fidx; v.fway = fway;
    v.ftag = ftag; v.inv = inv; v.eh = eh; v.ew = ew; v.ev = ev;
    return v;
  endfunction

  // Drive one cycle of inputs and stop at the following negedge.
  task automatic apply(input vec_t v, input logic rr);
    req_valid      = v.rv;
    req_index      = v.idx;
    req_tag        = v.tag;
    fill_valid     = v.fv;
    fill_index     = v.fidx;
    fill_way       = v.fway;
    fill_tag       = v.ftag;
    invalidate_all = v.inv;
    resp_ready     = rr;
    exp_cur.hit    = v.eh;
    exp_cur.way    = v.ew;
    exp_cur.vic    = v.ev;
    @(negedge clk);
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: pop on handshake, push on accept, check one-cycle latency.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (pend) chk("resp_latency", resp_valid, 1);
      if (resp_valid && resp_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_resp: got response with empty scoreboard at %0t", $time);
        end else begin
          e = sb.pop_front();
          chk("resp_hit", resp_hit, e.hit);
          chk("resp_way", resp_way, e.way);
          chk("resp_victim", resp_victim, e.vic);
        end
      end
      pend = req_valid && req_ready;
      if (pend) sb.push_back(exp_cur);
    end else begin
      pend = 1'b0;
    end
  end

  initial begin
    vec_t idle;
    vec_t v;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    //       rv idx tag       fv fidx fway ftag     inv eh ew ev
    tbl.push_back(mk(1, 5,  20'hABCDE, 0, 0,  0, 0,         0, 0, 0, 0));
    tbl.push_back(mk(0, 0,  0,         1, 5,  2, 20'hABCDE, 0, 0, 0, 0));
    tbl.push_back(mk(1, 5,  20'hABCDE, 0, 0,  0, 0,         0, 1, 2, 0));
    tbl.push_back(mk(0, 0,  0,         1, 3,  0, 20'h11111, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0,  0,         1, 3,  1, 20'h22222, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0,  0,         1, 3,  2, 20'h33333, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0,  0,         1, 3,  3, 20'h44444, 0, 0, 0, 0));
    tbl.push_back(mk(1, 3,  20'h55555, 0, 0,  0, 0,         0, 0, 0, 0));
    tbl.push_back(mk(0, 0,  0,         1, 3,  0, 20'h66666, 0, 0, 0, 0));
    tbl.push_back(mk(1, 3,  20'h55555, 0, 0,  0, 0,         0, 0, 0, 1));
    tbl.push_back(mk(1, 3,  20'h33333, 0, 0,  0, 0,         0, 1, 2, 1));
    tbl.push_back(mk(1, 3,  20'h11111, 0, 0,  0, 0,         0, 0, 0, 1));
    tbl.push_back(mk(1, 3,  20'h66666, 0, 0,  0, 0,         0, 1, 0, 1));
    tbl.push_back(mk(1, 9,  20'h12345, 1, 9,  1, 20'h12345, 0, 0, 0, 0));
    tbl.push_back(mk(1, 9,  20'h12345, 0, 0,  0, 0,         0, 1, 1, 0));
    tbl.push_back(mk(1, 5,  20'hABCDE, 1, 9,  3, 20'h12345, 0, 1, 2, 0));
    tbl.push_back(mk(1, 9,  20'h12345, 0, 0,  0, 0,         0, 1, 1, 0));
    tbl.push_back(mk(0, 0,  0,         1, 63, 3, 20'hFFFFF, 0, 0, 0, 0));
    tbl.push_back(mk(1, 63, 20'hFFFFF, 0, 0,  0, 0,         0, 1, 3, 0));
    tbl.push_back(mk(1, 0,  20'hFFFFF, 0, 0,  0, 0,         0, 0, 0, 0));
    tbl.push_back(mk(0, 0,  0,         1, 7,  0, 20'h77777, 0, 0, 0, 0));
    tbl.push_back(mk(1, 7,  20'h77777, 0, 0,  0, 0,         0, 1, 0, 1));
    tbl.push_back(mk(1, 7,  20'h77777, 1, 7,  1, 20'h77777, 1, 1, 0, 1));
    tbl.push_back(mk(1, 7,  20'h77777, 0, 0,  0, 0,         0, 0, 0, 0));
    tbl.push_back(mk(1, 5,  20'hABCDE, 0, 0,  0, 0,         0, 0, 0, 0));
    tbl.push_back(mk(1, 3,  20'h33333, 0, 0,  0, 0,         0, 0, 0, 0));

    // Reset, then check the post-reset state.
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    apply(idle, 1);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_hit", resp_hit, 0);
    chk("rst_resp_way", resp_way, 0);
    chk("rst_resp_victim", resp_victim, 0);
    finish_cycle();

    // Table-driven main sequence with the consumer always ready.
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], 1);
      chk("tbl_req_ready", req_ready, 1);
      finish_cycle();
    end

    // Re-populate idx63 way3 after the invalidate, drain, then stall the consumer.
    apply(mk(0, 0, 0, 1, 63, 3, 20'hFFFFF, 0, 0, 0, 0), 1);
    finish_cycle();
    apply(idle, 1);
    finish_cycle();
    apply(mk(1, 63, 20'hFFFFF, 0, 0, 0, 0, 0, 1, 3, 0), 0);
    finish_cycle();
    for (int c = 0; c < 3; c++) begin
      if (c == 0) v = mk(1, 0, 20'h00000, 1, 63, 0, 20'hFFFFF, 0, 0, 0, 0);
      else        v = mk(1, 0, 20'h00000, 0, 0,  0, 0,         0, 0, 0, 0);
      apply(v, 0);
      chk("stall_req_ready", req_ready, 0);
      chk("stall_resp_valid", resp_valid, 1);
      chk("stall_resp_hit", resp_hit, 1);
      chk("stall_resp_way", resp_way, 3);
      chk("stall_resp_victim", resp_victim, 0);
      finish_cycle();
    end
    apply(mk(1, 0, 20'h00000, 0, 0, 0, 0, 0, 0, 0, 0), 1);
    chk("release_req_ready", req_ready, 1);
    finish_cycle();
    apply(idle, 1);
    chk("b2b_resp_valid", resp_valid, 1);
    finish_cycle();
    apply(idle, 1);
    chk("drain_resp_valid", resp_valid, 0);
    finish_cycle();

    // Reset while a response is pending; same-cycle fill and request are ignored.
    apply(mk(1, 5, 20'hABCDE, 1, 5, 0, 20'hABCDE, 0, 0, 0, 0), 0);
    finish_cycle();
    reset = 1'b1;
    apply(mk(1, 5, 20'hABCDE, 1, 5, 0, 20'hABCDE, 0, 0, 0, 0), 0);
    finish_cycle();
    reset = 1'b0;
    sb.delete();
    apply(idle, 1);
    chk("rst2_resp_valid", resp_valid, 0);
    chk("rst2_resp_hit", resp_hit, 0);
    chk("rst2_resp_way", resp_way, 0);
    chk("rst2_req_ready", req_ready, 1);
    finish_cycle();
    apply(mk(1, 5, 20'hABCDE, 0, 0, 0, 0, 0, 0, 0, 0), 1);
    finish_cycle();
    apply(idle, 1);
    finish_cycle();
    apply(idle, 1);
    chk("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
